ngp_alu_arbiter: RTL and testbench
==================================

// Module: ngp_alu_arbiter
// PURPOSE
//  Shares the single ngpalu datapath between NUM_REQ requesters (fetch/addr-calc, execute, debug).
//  Round-robin arbitration, valid/ready request and response channels.
//  Two-stage pipeline: issue register, then result register. Throughput 1 op/cycle.
//  Sits between the core's issue logic and ngpalu. Returns result, flags and requester id.
// PARAMETERS
//  W        16  datapath width (ALU operand/result bits)
//  NUM_REQ  2   number of requesters, legal 2..8
//  ID_W     $clog2(NUM_REQ)  requester-id width (derived, do not override)
// PORTS
//  clk          in   1            core clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NUM_REQ      per-requester op valid
//  req_ready    out  NUM_REQ      per-requester accept (one-hot or zero)
//  req_opcode   in   NUM_REQ*3    per-requester ALU opcode
//  req_zy       in   NUM_REQ      per-requester force-Y-to-zero
//  req_rx       in   NUM_REQ*W    per-requester X operand
//  req_ry       in   NUM_REQ*W    per-requester Y operand
//  resp_valid   out  1            result available
//  resp_ready   in   1            consumer accepts result
//  resp_id      out  ID_W         requester that issued the op
//  resp_data    out  W            ALU result
//  resp_zero    out  1            resp_data == 0
//  resp_neg     out  1            resp_data[W-1]
//  ops_done     out  16           count of completed responses, wraps 0xFFFF->0
// BEHAVIOUR
//  - Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT X, 100 ADD, 101 SUB X-Y, 110 X+1, 111 X-1.
//  - zy=1 forces Y=0 before the op. All arithmetic is mod 2^W; no carry/overflow out.
//  - Request handshake: transfer when req_valid[i] && req_ready[i].
//  - Requester holds opcode/zy/rx/ry stable while valid and not ready. Arbiter does not sample early.
//  - req_ready: at most one bit high. High only for the arbitration winner, and only when S1 can load.
//    S1 can load when S1 is empty, or S1 moves to S2 this cycle.
//  - Arbitration: rotating priority starting at (last_grant+1) mod NUM_REQ.
//    last_grant updates only on an accepted transfer. Reset last_grant = NUM_REQ-1, so req 0 wins first.
//  - S1 (issue reg): {valid, id, opcode, zy, rx, ry}. Drives ngpalu combinationally.
//  - S2 (result reg) loads from ALU output when S1 valid and (S2 empty or S2 handshake this cycle).
//  - Latency: accept in cycle N gives resp_valid in cycle N+2 if no stall. Back-to-back accepts give back-to-back responses.
//  - Backpressure: resp_ready=0 with S2 full makes S1 hold. With S1 also full, all req_ready go low. No op is dropped or duplicated.
//  - Simultaneous S2 drain and S1 advance and new accept in one cycle: all three occur, full throughput.
//  - resp_data/resp_id/flags stay stable while resp_valid && !resp_ready.
//  - ops_done increments by 1 on each resp_valid && resp_ready.
//  - Reset (async assert, any time): S1/S2 valid=0, resp_valid=0, req_ready=0, resp_data=0, resp_id=0,
//    resp_zero=0, resp_neg=0, ops_done=0, last_grant=NUM_REQ-1. In-flight ops are discarded with no response.
//    Deassertion takes effect at the next clk edge.
// STRUCTURE
//  - ngp_pkg: alu_op_e enum (AND,OR,XOR,NOTX,ADD,SUB,INCX,DECX), ALU_W=16, issue_t struct {id,op,zy,rx,ry}.
//  - Sub-module ngp_rr_arbiter #(NUM_REQ): req vector + advance enable -> one-hot grant, holds last_grant pointer.
//  - ngpalu instantiated once, fed from S1.
// TESTING
//  1 Single op: req0 ADD rx=0x0005 ry=0x0003, resp_ready=1 -> accept cycle N; cycle N+2 resp_valid, data=0x0008, id=0, zero=0.
//  2 Contention: req0 and req1 valid every cycle, 4 ops each -> grants alternate 0,1,0,1...; responses in grant order; ops_done=8.
//  3 Backpressure: 3 ops issued, resp_ready=0 for 5 cycles -> S2 and S1 fill, req_ready=0, resp_data stable.
//    Release -> 3 results in order, none lost.
//  4 Opcode sweep rx=0x8000 ry=0x0001: SUB->0x7FFF neg=0; DECX->0x7FFF; INCX 0xFFFF->0x0000 zero=1;
//    NOTX 0x8000->0x7FFF; ADD zy=1->0x8000 neg=1.
//  5 Reset mid-flight: assert rst_n=0 with S1 and S2 full -> all outputs 0 immediately.
//    After release, no stale resp; first grant goes to req0.
//  6 Counter wrap: preload through 0xFFFF completions -> next completion ops_done=0x0000.

Source files
------------

// File: rtl/ngp_pkg.sv
// Shared types for the ngpalu sharing slice: ALU opcode encoding and the issue-register payload.
// issue_t carries ALU_W-wide operands, so users of it run the datapath at ALU_W bits.
package ngp_pkg;

    localparam int ALU_W    = 16;
    localparam int MAX_ID_W = 3;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOTX = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_INCX = 3'b110,
        OP_DECX = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        alu_op_e             op;
        logic                zy;
        logic [ALU_W-1:0]    rx;
        logic [ALU_W-1:0]    ry;
    } issue_t;

endpackage

// File: rtl/ngp_rr_arbiter.sv
// Rotating-priority arbiter: search starts one past the last accepted grant.
// The pointer only moves when the granted request is actually transferred.
module ngp_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grantIdx_o
);

    logic [ID_W-1:0] lastGrant_q;
    logic [ID_W-1:0] lastGrant_d;
    logic            found;
    int              cand;

    always_comb begin
        grant_o    = '0;
        grantIdx_o = lastGrant_q;
        found      = 1'b0;
        cand       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(lastGrant_q) + off) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == cand) && req_i[i]) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    grantIdx_o = ID_W'(i);
                end
            end
        end
        lastGrant_d = advance_i ? grantIdx_o : lastGrant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/ngpalu.sv
// Purely combinational ngp ALU: eight ops, optional force-Y-to-zero, all arithmetic mod 2^W.
module ngpalu
    import ngp_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  alu_op_e        op_i,
    input  logic           zy_i,
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    output logic [W-1:0]   result_o
);

    logic [W-1:0] yEff;

    always_comb begin
        yEff     = zy_i ? '0 : y_i;
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = x_i & yEff;
            OP_OR:   result_o = x_i | yEff;
            OP_XOR:  result_o = x_i ^ yEff;
            OP_NOTX: result_o = ~x_i;
            OP_ADD:  result_o = x_i + yEff;
            OP_SUB:  result_o = x_i - yEff;
            OP_INCX: result_o = x_i + W'(1);
            OP_DECX: result_o = x_i - W'(1);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ngp_alu_arbiter.sv
// Shares one ngpalu between NUM_REQ requesters: round-robin accept into S1 (issue),
// ALU result captured in S2 (response). One op per cycle with full backpressure.
module ngp_alu_arbiter
    import ngp_pkg::*;
#(
    parameter  int W       = ALU_W,
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*3-1:0] req_opcode,
    input  logic [NUM_REQ-1:0]   req_zy,
    input  logic [NUM_REQ*W-1:0] req_rx,
    input  logic [NUM_REQ*W-1:0] req_ry,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [W-1:0]         resp_data,
    output logic                 resp_zero,
    output logic                 resp_neg,
    output logic [15:0]          ops_done
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;
    logic               s2Fire;
    logic               s2CanLoad;
    logic               s1Adv;
    logic               s1CanLoad;
    logic               accept;
    issue_t             issueSel;
    logic [W-1:0]       aluResult;

    issue_t             s1_q, s1_d;
    logic               s1Valid_q, s1Valid_d;
    logic               s2Valid_q, s2Valid_d;
    logic [ID_W-1:0]    s2Id_q, s2Id_d;
    logic [W-1:0]       s2Data_q, s2Data_d;
    logic               s2Zero_q, s2Zero_d;
    logic               s2Neg_q, s2Neg_d;
    logic [15:0]        opsDone_q, opsDone_d;

    ngp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_valid),
        .advance_i  (accept),
        .grant_o    (grant),
        .grantIdx_o (grantIdx)
    );

    ngpalu #(
        .W (W)
    ) u_alu (
        .op_i     (s1_q.op),
        .zy_i     (s1_q.zy),
        .x_i      (s1_q.rx),
        .y_i      (s1_q.ry),
        .result_o (aluResult)
    );

    // Ready is gated by rst_n so nothing can be accepted while the flops are held in reset.
    always_comb begin
        s2Fire    = s2Valid_q && resp_ready;
        s2CanLoad = !s2Valid_q || resp_ready;
        s1Adv     = s1Valid_q && s2CanLoad;
        s1CanLoad = !s1Valid_q || s1Adv;
        req_ready = (s1CanLoad && rst_n) ? grant : '0;
        accept    = |(req_valid & req_ready);
    end

    always_comb begin
        issueSel    = '0;
        issueSel.id = MAX_ID_W'(grantIdx);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                issueSel.op = alu_op_e'(req_opcode[i*3 +: 3]);
                issueSel.zy = req_zy[i];
                issueSel.rx = req_rx[i*W +: W];
                issueSel.ry = req_ry[i*W +: W];
            end
        end
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1_d      = s1_q;
        if (accept) begin
            s1Valid_d = 1'b1;
            s1_d      = issueSel;
        end else if (s1Adv) begin
            s1Valid_d = 1'b0;
        end

        s2Valid_d = s2Valid_q;
        s2Id_d    = s2Id_q;
        s2Data_d  = s2Data_q;
        s2Zero_d  = s2Zero_q;
        s2Neg_d   = s2Neg_q;
        if (s1Adv) begin
            s2Valid_d = 1'b1;
            s2Id_d    = s1_q.id[ID_W-1:0];
            s2Data_d  = aluResult;
            s2Zero_d  = (aluResult == '0);
            s2Neg_d   = aluResult[W-1];
        end else if (s2Fire) begin
            s2Valid_d = 1'b0;
        end

        opsDone_d = opsDone_q + {15'd0, s2Fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1_q      <= '0;
            s2Valid_q <= 1'b0;
            s2Id_q    <= '0;
            s2Data_q  <= '0;
            s2Zero_q  <= 1'b0;
            s2Neg_q   <= 1'b0;
            opsDone_q <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1_q      <= s1_d;
            s2Valid_q <= s2Valid_d;
            s2Id_q    <= s2Id_d;
            s2Data_q  <= s2Data_d;
            s2Zero_q  <= s2Zero_d;
            s2Neg_q   <= s2Neg_d;
            opsDone_q <= opsDone_d;
        end
    end

    assign resp_valid = s2Valid_q;
    assign resp_id    = s2Id_q;
    assign resp_data  = s2Data_q;
    assign resp_zero  = s2Zero_q;
    assign resp_neg   = s2Neg_q;
    assign ops_done   = opsDone_q;

endmodule

// File: tb/tb_ngp_alu_arbiter.sv
// Scoreboard bench for ngp_alu_arbiter: expected results queued on accept, compared on response.
module tb_ngp_alu_arbiter;
    import ngp_pkg::*;

    localparam int W       = 16;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   reqValid = '0;
    logic [NUM_REQ-1:0]   reqReady;
    logic [NUM_REQ*3-1:0] reqOpcode = '0;
    logic [NUM_REQ-1:0]   reqZy = '0;
    logic [NUM_REQ*W-1:0] reqRx = '0;
    logic [NUM_REQ*W-1:0] reqRy = '0;
    logic                 respValid;
    logic                 respReady = 1'b1;
    logic [ID_W-1:0]      respId;
    logic [W-1:0]         respData;
    logic                 respZero;
    logic                 respNeg;
    logic [15:0]          opsDone;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [W-1:0]    data;
        int              acceptCycle;
    } expT;

    expT         expQ[$];
    expT         popped;
    expT         pushed;
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          lastGrant = NUM_REQ - 1;
    int          winner;
    int          cand;
    logic [15:0] expOps = '0;
    logic [15:0] baseOps;
    bit          checkLatency = 1'b0;
    int          nOps;

    always #5 clk = ~clk;

    ngp_alu_arbiter #(
        .W       (W),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_opcode (reqOpcode),
        .req_zy     (reqZy),
        .req_rx     (reqRx),
        .req_ry     (reqRy),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_id    (respId),
        .resp_data  (respData),
        .resp_zero  (respZero),
        .resp_neg   (respNeg),
        .ops_done   (opsDone)
    );

    function automatic logic [W-1:0] aluModel(input logic [2:0] op, input logic zy,
                                              input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] yy;
        yy = zy ? '0 : y;
        case (op)
            3'b000:  return x & yy;
            3'b001:  return x | yy;
            3'b010:  return x ^ yy;
            3'b011:  return ~x;
            3'b100:  return x + yy;
            3'b101:  return x - yy;
            3'b110:  return x + 16'd1;
            default: return x - 16'd1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    // Arbitration model, accept-time push and response-time pop all happen mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            lastGrant = NUM_REQ - 1;
            expOps    = '0;
        end else begin
            checkOutput("opsDone", opsDone, expOps);
            if (reqReady != '0) begin
                winner = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (lastGrant + k) % NUM_REQ;
                    if (winner < 0 && reqValid[cand]) winner = cand;
                end
                checkOutput("grant", reqReady, (winner < 0) ? 32'd0 : (32'd1 << winner));
                if (winner >= 0) begin
                    lastGrant          = winner;
                    pushed.id          = ID_W'(winner);
                    pushed.data        = aluModel(reqOpcode[winner*3 +: 3], reqZy[winner],
                                                  reqRx[winner*W +: W], reqRy[winner*W +: W]);
                    pushed.acceptCycle = cycleCnt;
                    expQ.push_back(pushed);
                end
            end
            if (respValid && respReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousResp", 32'd1, 32'd0);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("respId", respId, popped.id);
                    checkOutput("respData", respData, popped.data);
                    checkOutput("respZero", respZero, (popped.data == '0));
                    checkOutput("respNeg", respNeg, popped.data[W-1]);
                    if (checkLatency) checkOutput("latency", cycleCnt - popped.acceptCycle, 2);
                end
                expOps = expOps + 16'd1;
            end
        end
    end

    // Present one op on requester r and hold it until the arbiter accepts it.
    task automatic applyStimulus(input int r, input logic [2:0] op, input logic zy,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
        int waited = 0;
        reqOpcode[r*3 +: 3] = op;
        reqZy[r]            = zy;
        reqRx[r*W +: W]     = x;
        reqRy[r*W +: W]     = y;
        reqValid[r]         = 1'b1;
        @(negedge clk);
        while (!reqReady[r] && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!reqReady[r]) checkOutput("acceptTimeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        reqValid[r] = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((expQ.size() != 0 || respValid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        checkOutput("drainLeft", expQ.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reqValid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReqReady", reqReady, 0);
        checkOutput("rstRespValid", respValid, 0);
        checkOutput("rstRespData", respData, 0);
        checkOutput("rstOpsDone", opsDone, 0);
        reqValid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] single op");
        checkLatency = 1'b1;
        applyStimulus(0, 3'b100, 1'b0, 16'h0005, 16'h0003);
        drain();
        checkLatency = 1'b0;

        $display("[TB] contention");
        baseOps = expOps;
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(0, 3'b100, 1'b0, W'(i), 16'h0010);
            end
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1, 3'b101, 1'b0, W'(16'h0100 + i), W'(i));
            end
        join
        drain();
        checkOutput("contentionOps", opsDone - baseOps, 8);

        $display("[TB] backpressure");
        baseOps   = expOps;
        respReady = 1'b0;
        fork
            begin
                applyStimulus(0, 3'b010, 1'b0, 16'hAAAA, 16'h0F0F);
                applyStimulus(0, 3'b001, 1'b0, 16'h1200, 16'h0034);
                applyStimulus(0, 3'b000, 1'b0, 16'hFFFF, 16'h00F0);
            end
        join_none
        waitCycles(6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallValid", respValid, 1);
            checkOutput("stallReady", reqReady, 0);
            checkOutput("stallData", respData, 16'hA5A5);
        end
        @(posedge clk);
        #1;
        respReady = 1'b1;
        wait fork;
        drain();
        checkOutput("backpressureOps", opsDone - baseOps, 3);

        $display("[TB] opcode sweep");
        applyStimulus(1, 3'b101, 1'b0, 16'h8000, 16'h0001);
        applyStimulus(1, 3'b111, 1'b0, 16'h8000, 16'h0001);
        applyStimulus(1, 3'b110, 1'b0, 16'hFFFF, 16'h0001);
        applyStimulus(1, 3'b011, 1'b0, 16'h8000, 16'h0001);
        applyStimulus(1, 3'b100, 1'b1, 16'h8000, 16'h0001);
        drain();

        $display("[TB] reset mid-flight");
        respReady = 1'b0;
        applyStimulus(0, 3'b100, 1'b0, 16'h0001, 16'h0001);
        applyStimulus(1, 3'b111, 1'b0, 16'h0000, 16'h0000);
        #2;
        rst_n    = 1'b0;
        reqValid = 2'b11;
        #1;
        checkOutput("midRstRespValid", respValid, 0);
        checkOutput("midRstReqReady", reqReady, 0);
        checkOutput("midRstRespData", respData, 0);
        checkOutput("midRstRespId", respId, 0);
        checkOutput("midRstRespNeg", respNeg, 0);
        checkOutput("midRstRespZero", respZero, 0);
        checkOutput("midRstOpsDone", opsDone, 0);
        @(negedge clk);
        reqValid  = '0;
        respReady = 1'b1;
        #1;
        rst_n = 1'b1;
        waitCycles(4);
        checkOutput("postRstRespValid", respValid, 0);
        fork
            applyStimulus(0, 3'b000, 1'b0, 16'h00FF, 16'h0F0F);
            applyStimulus(1, 3'b001, 1'b0, 16'h00FF, 16'h0F0F);
        join
        drain();

        $display("[TB] counter wrap");
        nOps = 32'(16'hFFFF - expOps);
        for (int i = 0; i < nOps; i++) applyStimulus(0, 3'b100, 1'b0, W'(i), 16'h0001);
        drain();
        checkOutput("preWrap", opsDone, 16'hFFFF);
        applyStimulus(1, 3'b010, 1'b0, 16'h1234, 16'h1234);
        drain();
        checkOutput("wrap", opsDone, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
